// File: rtl/seq_pkg.sv
// Shared definitions for the serial 1001 sequence family (generator and detectors).
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam int         PAT_W_DEFAULT   = 4;
    localparam logic [3:0] PATTERN_DEFAULT = 4'b1001;

endpackage

// File: rtl/seq_pattern_gen_1001_if.sv
// Burst request and serial output bundle between a pattern generator and its user.
interface seq_pattern_gen_1001_if #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
);
    logic             start;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             data_out;
    logic             data_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, repeat_cnt, gap_len,
        input  data_out, data_valid, busy, done
    );

    modport slave (
        input  start, repeat_cnt, gap_len,
        output data_out, data_valid, busy, done
    );
endinterface

// File: rtl/seq_down_counter.sv
// Loadable down counter with a zero flag; load wins over decrement, never wraps below 0.
module seq_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (dec_i && (count_q != '0))
            count_d = count_q - WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/seq_pattern_gen_1001.sv
// Serialises a fixed pattern MSB first in bursts of repeat_cnt copies separated by gap_len idle cycles.
module seq_pattern_gen_1001
    import seq_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEFAULT),
    parameter int               CNT_W   = 4,
    parameter int               GAP_W   = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seq_pattern_gen_1001_if.slave bus
);
    localparam int               IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic             data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             reps_load, reps_dec, reps_zero;
    logic             gap_load, gap_dec, gap_zero;
    logic [CNT_W-1:0] reps_load_val;
    logic [PAT_W-1:0] pat_rev;

    // Reversed so that bit_idx addresses the transmit order directly.
    always_comb begin
        pat_rev = '0;
        for (int i = 0; i < PAT_W; i++)
            pat_rev[i] = PATTERN[PAT_W-1-i];
    end

    // Counters hold "remaining minus one" so the zero flag marks the final repetition/gap cycle.
    assign reps_load_val = (bus.repeat_cnt == '0) ? '0 : bus.repeat_cnt - CNT_W'(1);

    seq_down_counter #(.WIDTH(CNT_W)) u_reps (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (reps_load),
        .load_val_i (reps_load_val),
        .dec_i      (reps_dec),
        .zero_o     (reps_zero)
    );

    seq_down_counter #(.WIDTH(GAP_W)) u_gap (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (gap_load),
        .load_val_i (gap_len_q - GAP_W'(1)),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
    );

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        gap_len_d    = gap_len_q;
        data_out_d   = 1'b0;
        data_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        reps_load    = 1'b0;
        reps_dec     = 1'b0;
        gap_load     = 1'b0;
        gap_dec      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The done cycle is still IDLE but must not accept a new burst.
                if (bus.start && !done_q) begin
                    state_d      = SEND;
                    bit_idx_d    = '0;
                    gap_len_d    = bus.gap_len;
                    reps_load    = 1'b1;
                    data_out_d   = pat_rev[0];
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            SEND: begin
                if (bit_idx_q == LAST_IDX) begin
                    bit_idx_d = '0;
                    if (reps_zero) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        reps_dec = 1'b1;
                        busy_d   = 1'b1;
                        if (gap_len_q != '0) begin
                            state_d  = GAP;
                            gap_load = 1'b1;
                        end else begin
                            data_out_d   = pat_rev[0];
                            data_valid_d = 1'b1;
                        end
                    end
                end else begin
                    bit_idx_d    = bit_idx_q + IDX_W'(1);
                    data_out_d   = pat_rev[bit_idx_q + IDX_W'(1)];
                    data_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_zero) begin
                    state_d      = SEND;
                    bit_idx_d    = '0;
                    data_out_d   = pat_rev[0];
                    data_valid_d = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            gap_len_q    <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            gap_len_q    <= gap_len_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_seq_pattern_gen_1001.sv
// Scoreboard bench for seq_pattern_gen_1001: per-cycle expected output traces plus a 1001 loopback detector.
module tb_seq_pattern_gen_1001;

    localparam logic [3:0] PAT = 4'b1001;

    typedef struct packed {
        logic dout;
        logic valid;
        logic busy;
        logic done;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_pattern_gen_1001_if #(.CNT_W(4), .GAP_W(3)) bus ();

    seq_pattern_gen_1001 #(
        .PAT_W   (4),
        .PATTERN (4'b1001),
        .CNT_W   (4),
        .GAP_W   (3)
    ) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    obs_t       exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         busy_until  = -1;
    int         pats_sent   = 0;
    int         pats0       = 0;
    int         hits        = 0;
    int         hits0       = 0;
    logic [3:0] det_sr      = 4'b0000;
    logic       final_req   = 1'b0;
    logic       final_done  = 1'b0;
    obs_t       act, want;

    // Monitor: every cycle the DUT shows activity or a response is owed, pop and compare.
    always @(negedge clk) begin
        act = obs_t'({bus.data_out, bus.data_valid, bus.busy, bus.done});
        if (exp_q.size() > 0 || act != 4'b0000) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'(4'b0000);
            vectors++;
            if (act !== want) begin
                miscompares++;
                $display("FAIL cycle_%0d dout/valid/busy/done: got %b required %b", cyc, act, want);
            end
        end
        if (bus.data_valid === 1'b1) begin
            det_sr = {det_sr[2:0], bus.data_out};
            if (det_sr == 4'b1001) hits++;
        end
        if (final_req && !final_done) begin
            vectors++;
            if ((hits - hits0) != (pats_sent - pats0)) begin
                miscompares++;
                $display("FAIL loopback_hits: got %0d required %0d", hits - hits0, pats_sent - pats0);
            end
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL drain: got %0d pending expected cycles required 0", exp_q.size());
            end
            final_done = 1'b1;
        end
    end

    // Reference: a burst is R copies of the pattern, G idle-but-busy cycles between copies, then one done cycle.
    task automatic accept(input int c, input logic [3:0] rc, input logic [2:0] gl);
        int r;
        r = (rc == 4'd0) ? 1 : int'(rc);
        for (int i = 0; i < r; i++) begin
            for (int b = 3; b >= 0; b--)
                exp_q.push_back(obs_t'({PAT[b], 1'b1, 1'b1, 1'b0}));
            if (i < r - 1)
                repeat (int'(gl)) exp_q.push_back(obs_t'(4'b0010));
        end
        exp_q.push_back(obs_t'(4'b0001));
        busy_until = c + r * 4 + (r - 1) * int'(gl) + 1;
        pats_sent += r;
    endtask

    task automatic step(input logic s, input logic [3:0] rc, input logic [2:0] gl);
        bus.start      = s;
        bus.repeat_cnt = rc;
        bus.gap_len    = gl;
        @(posedge clk);
        if (s && cyc > busy_until) accept(cyc, rc, gl);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 4'($urandom), 3'($urandom));
    endtask

    task automatic do_reset(input int n);
        bus.start = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        repeat (n) exp_q.push_back(obs_t'(4'b0000));
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n      = 1'b1;
        busy_until = cyc - 1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.repeat_cnt = 4'd0;
        bus.gap_len    = 3'd0;
        @(posedge clk);
        cyc = 1;
        #1;
        do_reset(3);

        step(1'b1, 4'd1, 3'd0);
        idle(8);
        step(1'b1, 4'd3, 3'd2);
        idle(20);
        step(1'b1, 4'd2, 3'd0);
        idle(12);

        // Re-pulses at t+2 and in the done cycle are ignored; t+6 starts a new burst.
        step(1'b1, 4'd0, 3'd5);
        step(1'b0, 4'd7, 3'd3);
        step(1'b1, 4'd9, 3'd1);
        step(1'b0, 4'd2, 3'd2);
        step(1'b0, 4'd5, 3'd4);
        step(1'b1, 4'd3, 3'd3);
        step(1'b1, 4'd1, 3'd0);
        idle(8);

        step(1'b1, 4'd3, 3'd1);
        step(1'b0, 4'd3, 3'd1);
        step(1'b0, 4'd3, 3'd1);
        do_reset(2);
        step(1'b1, 4'd1, 3'd0);
        idle(8);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(2);
            else step(($urandom % 6) == 0, 4'($urandom), 3'($urandom));
        end
        idle(200);

        hits0 = hits;
        pats0 = pats_sent;
        for (int i = 0; i < 2000; i++)
            step(($urandom % 5) == 0, 4'($urandom), 3'($urandom));
        idle(200);

        final_req = 1'b1;
        idle(3);
        if (!final_done) begin
            $display("FAIL final_checks: got not_run required run");
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        end else begin
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        end
        $finish;
    end

endmodule
